stream_omega_out_fifo: RTL and testbench



---
 rtl/stream_omega_out_fifo.sv | 161 ++++++++++++++++
 tb/tb_stream_omega_out_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_omega_out_fifo.sv
// Output-lane FIFO for the omega network with a per-source occupancy cap.
// Optional high-water mark on max_usage_o: define STREAM_OMEGA_OUT_FIFO_STATS_EN.
module stream_omega_out_fifo #(
  parameter int unsigned NumInp    = 2,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 8,
  parameter int unsigned MaxPerInp = 0,
  parameter int unsigned IdxWidth  = (NumInp > 1) ? $clog2(NumInp) : 1,
  parameter int unsigned CntWidth  = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [IdxWidth-1:0]  idx_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic [IdxWidth-1:0]  idx_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CntWidth-1:0]  usage_o,
  output logic [CntWidth-1:0]  max_usage_o
);

  localparam int unsigned         PtrWidth = $clog2(Depth);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
  localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxPerInp);
  localparam bit                  CapEn    = (MaxPerInp != 0);

  logic [DataWidth-1:0] data_mem_q [Depth];
  logic [IdxWidth-1:0]  idx_mem_q  [Depth];
  logic [PtrWidth-1:0]  wptr_q, wptr_d;
  logic [PtrWidth-1:0]  rptr_q, rptr_d;
  logic [CntWidth-1:0]  usage_q, usage_d;
  logic [CntWidth-1:0]  cnt_q [NumInp];
  logic [CntWidth-1:0]  cnt_d [NumInp];
  logic [CntWidth-1:0]  cnt_sel;
  logic [NumInp-1:0]    inc, dec;
  logic                 full, empty, push, pop;

  assign full  = (usage_q == DepthCnt);
  assign empty = (usage_q == '0);

  // Occupancy of the source currently offering an entry; gates ready_o.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < int'(NumInp); i++) begin
      if (idx_i == IdxWidth'(i)) cnt_sel = cnt_q[i];
    end
  end

  assign ready_o = !full && (!CapEn || (cnt_sel < MaxCnt));
  assign valid_o = !empty;
  assign data_o  = data_mem_q[rptr_q];
  assign idx_o   = idx_mem_q[rptr_q];
  assign usage_o = usage_q;

  // Handshakes in a flush cycle are discarded.
  assign push = valid_i && ready_o && !flush_i;
  assign pop  = valid_o && ready_i && !flush_i;

  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < int'(NumInp); i++) begin
      inc[i] = push && (idx_i == IdxWidth'(i));
      dec[i] = pop && (idx_o == IdxWidth'(i));
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    usage_d = usage_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      usage_d = '0;
      for (int i = 0; i < int'(NumInp); i++) cnt_d[i] = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      usage_d = usage_q + 1'b1;
      else if (pop && !push) usage_d = usage_q - 1'b1;
      for (int i = 0; i < int'(NumInp); i++) begin
        if (inc[i] && !dec[i])      cnt_d[i] = cnt_q[i] + 1'b1;
        else if (dec[i] && !inc[i]) cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      usage_q <= '0;
      for (int i = 0; i < int'(NumInp); i++) cnt_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      usage_q <= usage_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset: contents are only observed while valid_o is high.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem_q[wptr_q] <= data_i;
      idx_mem_q[wptr_q]  <= idx_i;
    end
  end

`ifdef STREAM_OMEGA_OUT_FIFO_STATS_EN
  logic [CntWidth-1:0] max_usage_q, max_usage_d;

  always_comb begin
    max_usage_d = max_usage_q;
    if (flush_i)                    max_usage_d = '0;
    else if (usage_d > max_usage_q) max_usage_d = usage_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) max_usage_q <= '0;
    else       max_usage_q <= max_usage_d;
  end

  assign max_usage_o = max_usage_q;
`else
  assign max_usage_o = '0;
`endif

`ifndef COMMON_CELLS_ASSERTS_OFF
  int unsigned cnt_sum;

  always_comb begin
    cnt_sum = 0;
    for (int i = 0; i < int'(NumInp); i++) cnt_sum += 32'(cnt_q[i]);
  end

  a_depth_pow2 : assert property (@(posedge clk_i)
    (Depth >= 2) && ((Depth & (Depth - 1)) == 0));
  a_max_per_inp : assert property (@(posedge clk_i) MaxPerInp <= Depth);
  a_idx_range : assert property (@(posedge clk_i) disable iff (rst_i)
    valid_i |-> (32'(idx_i) < NumInp));
  a_in_stable : assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_i && !ready_o) |=> (valid_i && $stable(data_i) && $stable(idx_i)));
  a_cnt_sum : assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_sum == 32'(usage_q));

  for (genvar g = 0; g < int'(NumInp); g++) begin : g_cnt_chk
    a_cnt_ovf : assert property (@(posedge clk_i) disable iff (rst_i)
      (inc[g] && !dec[g]) |-> (cnt_q[g] < DepthCnt));
    a_cnt_udf : assert property (@(posedge clk_i) disable iff (rst_i)
      (dec[g] && !inc[g]) |-> (cnt_q[g] != '0));
  end
`endif

endmodule

// File: tb/tb_stream_omega_out_fifo.sv
// Directed bench for stream_omega_out_fifo: an uncapped and a capped (MaxPerInp=2)
// instance, both NumInp=4, Depth=4, sharing clock and reset.
module tb_stream_omega_out_fifo;

`ifdef STREAM_OMEGA_OUT_FIFO_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        a_flush, a_valid_i, a_ready_o, a_valid_o, a_ready_i;
  logic [15:0] a_data_i, a_data_o;
  logic [1:0]  a_idx_i, a_idx_o;
  logic [2:0]  a_usage, a_max;
  logic        b_flush, b_valid_i, b_ready_o, b_valid_o, b_ready_i;
  logic [15:0] b_data_i, b_data_o;
  logic [1:0]  b_idx_i, b_idx_o;
  logic [2:0]  b_usage, b_max;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_omega_out_fifo #(.NumInp(4), .DataWidth(16), .Depth(4), .MaxPerInp(0)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(a_flush),
    .data_i(a_data_i), .idx_i(a_idx_i), .valid_i(a_valid_i), .ready_o(a_ready_o),
    .data_o(a_data_o), .idx_o(a_idx_o), .valid_o(a_valid_o), .ready_i(a_ready_i),
    .usage_o(a_usage), .max_usage_o(a_max)
  );

  stream_omega_out_fifo #(.NumInp(4), .DataWidth(16), .Depth(4), .MaxPerInp(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(b_flush),
    .data_i(b_data_i), .idx_i(b_idx_i), .valid_i(b_valid_i), .ready_o(b_ready_o),
    .data_o(b_data_o), .idx_o(b_idx_o), .valid_o(b_valid_o), .ready_i(b_ready_i),
    .usage_o(b_usage), .max_usage_o(b_max)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", a_valid_o); end
    n_checks++; if (a_usage !== 3'd0) begin n_fail++; $display("FAIL reset_usage: got %0d want 0", a_usage); end
    n_checks++; if (a_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_a: got %0b want 1", a_ready_o); end
    n_checks++; if (a_max !== 3'd0) begin n_fail++; $display("FAIL reset_max: got %0d want 0", a_max); end
    n_checks++; if (b_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_b: got %0b want 1", b_ready_o); end
    n_checks++; if (b_usage !== 3'd0) begin n_fail++; $display("FAIL reset_usage_b: got %0d want 0", b_usage); end
  endtask

  task automatic test_fill_drain();
    logic [15:0] exp_d;
    logic [2:0]  exp_max;
    a_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_valid_i = 1'b1;
      a_data_i  = 16'hA000 + 16'(k);
      a_idx_i   = 2'(k);
      #1;
      n_checks++; if (a_ready_o !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %0b want 1", k, a_ready_o); end
      tick();
    end
    a_valid_i = 1'b0;
    #1;
    n_checks++; if (a_ready_o !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", a_ready_o); end
    n_checks++; if (a_usage !== 3'd4) begin n_fail++; $display("FAIL full_usage: got %0d want 4", a_usage); end
    a_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = 16'hA000 + 16'(k);
      n_checks++;
      if (a_valid_o !== 1'b1 || a_data_o !== exp_d || a_idx_o !== 2'(k)) begin
        n_fail++;
        $display("FAIL drain[%0d]: got v=%0b d=%h i=%0d want v=1 d=%h i=%0d", k, a_valid_o, a_data_o, a_idx_o, exp_d, k);
      end
      tick();
    end
    n_checks++; if (a_valid_o !== 1'b0 || a_usage !== 3'd0) begin n_fail++; $display("FAIL drain_empty: got v=%0b u=%0d want v=0 u=0", a_valid_o, a_usage); end
    exp_max = StatsOn ? 3'd4 : 3'd0;
    n_checks++; if (a_max !== exp_max) begin n_fail++; $display("FAIL drain_max: got %0d want %0d", a_max, exp_max); end
    a_ready_i = 1'b0;
  endtask

  task automatic test_latency();
    a_ready_i = 1'b1;
    a_valid_i = 1'b1;
    a_data_i  = 16'h1234;
    a_idx_i   = 2'd2;
    #1;
    n_checks++; if (a_valid_o !== 1'b0) begin n_fail++; $display("FAIL lat_bypass: got %0b want 0", a_valid_o); end
    tick();
    a_valid_i = 1'b0;
    #1;
    n_checks++;
    if (a_valid_o !== 1'b1 || a_data_o !== 16'h1234 || a_idx_o !== 2'd2) begin
      n_fail++;
      $display("FAIL lat_n1: got v=%0b d=%h i=%0d want v=1 d=1234 i=2", a_valid_o, a_data_o, a_idx_o);
    end
    tick();
    n_checks++; if (a_valid_o !== 1'b0 || a_usage !== 3'd0) begin n_fail++; $display("FAIL lat_pop: got v=%0b u=%0d want v=0 u=0", a_valid_o, a_usage); end
    a_ready_i = 1'b0;
  endtask

  task automatic test_cap();
    b_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b_valid_i = 1'b1;
      b_data_i  = 16'hB000 + 16'(k);
      b_idx_i   = 2'd1;
      tick();
    end
    b_valid_i = 1'b0;
    #1;
    n_checks++; if (b_ready_o !== 1'b0) begin n_fail++; $display("FAIL cap_stall: got %0b want 0", b_ready_o); end
    n_checks++; if (b_usage !== 3'd2) begin n_fail++; $display("FAIL cap_usage2: got %0d want 2", b_usage); end
    b_valid_i = 1'b1;
    b_idx_i   = 2'd0;
    b_data_i  = 16'hB002;
    #1;
    n_checks++; if (b_ready_o !== 1'b1) begin n_fail++; $display("FAIL cap_other_idx: got %0b want 1", b_ready_o); end
    tick();
    b_valid_i = 1'b0;
    b_idx_i   = 2'd1;
    b_ready_i = 1'b1;
    #1;
    n_checks++; if (b_ready_o !== 1'b0) begin n_fail++; $display("FAIL cap_no_ready_path: got %0b want 0", b_ready_o); end
    n_checks++;
    if (b_usage !== 3'd3 || b_data_o !== 16'hB000 || b_idx_o !== 2'd1) begin
      n_fail++;
      $display("FAIL cap_head0: got u=%0d d=%h i=%0d want u=3 d=b000 i=1", b_usage, b_data_o, b_idx_o);
    end
    tick();
    b_ready_i = 1'b0;
    #1;
    n_checks++; if (b_ready_o !== 1'b1) begin n_fail++; $display("FAIL cap_release: got %0b want 1", b_ready_o); end
    n_checks++; if (b_usage !== 3'd2 || b_data_o !== 16'hB001) begin n_fail++; $display("FAIL cap_head1: got u=%0d d=%h want u=2 d=b001", b_usage, b_data_o); end
    b_ready_i = 1'b1;
    tick();
    n_checks++; if (b_data_o !== 16'hB002 || b_idx_o !== 2'd0) begin n_fail++; $display("FAIL cap_head2: got d=%h i=%0d want d=b002 i=0", b_data_o, b_idx_o); end
    tick();
    n_checks++; if (b_valid_o !== 1'b0) begin n_fail++; $display("FAIL cap_empty: got %0b want 0", b_valid_o); end
    b_ready_i = 1'b0;
  endtask

  task automatic test_full_pop_and_stream();
    logic [17:0] q[$];
    logic [17:0] exp_e;
    a_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a_valid_i = 1'b1;
      a_data_i  = 16'hC000 + 16'(k);
      a_idx_i   = 2'(k);
      tick();
    end
    a_valid_i = 1'b1;
    a_data_i  = 16'hC004;
    a_idx_i   = 2'd0;
    a_ready_i = 1'b1;
    #1;
    n_checks++; if (a_ready_o !== 1'b0) begin n_fail++; $display("FAIL fullpop_refuse: got %0b want 0", a_ready_o); end
    tick();
    a_ready_i = 1'b0;
    #1;
    n_checks++;
    if (a_usage !== 3'd3 || a_data_o !== 16'hC001 || a_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fullpop_after: got u=%0d d=%h r=%0b want u=3 d=c001 r=1", a_usage, a_data_o, a_ready_o);
    end
    tick();
    a_valid_i = 1'b0;
    n_checks++; if (a_usage !== 3'd4) begin n_fail++; $display("FAIL fullpop_refill: got %0d want 4", a_usage); end
    a_ready_i = 1'b1;
    tick();
    tick();
    q.push_back({2'd3, 16'hC003});
    q.push_back({2'd0, 16'hC004});
    for (int k = 0; k < 20; k++) begin
      a_valid_i = 1'b1;
      a_data_i  = 16'hD000 + 16'(k);
      a_idx_i   = 2'(k);
      #1;
      exp_e = q.pop_front();
      n_checks++;
      if (a_valid_o !== 1'b1 || a_ready_o !== 1'b1 || {a_idx_o, a_data_o} !== exp_e) begin
        n_fail++;
        $display("FAIL stream_head[%0d]: got v=%0b r=%0b i=%0d d=%h want v=1 r=1 i=%0d d=%h",
                 k, a_valid_o, a_ready_o, a_idx_o, a_data_o, exp_e[17:16], exp_e[15:0]);
      end
      tick();
      q.push_back({2'(k), 16'hD000 + 16'(k)});
      n_checks++; if (a_usage !== 3'd2) begin n_fail++; $display("FAIL stream_usage[%0d]: got %0d want 2", k, a_usage); end
    end
    a_valid_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_e = q.pop_front();
      n_checks++;
      if (a_valid_o !== 1'b1 || {a_idx_o, a_data_o} !== exp_e) begin
        n_fail++;
        $display("FAIL stream_tail[%0d]: got v=%0b i=%0d d=%h want v=1 i=%0d d=%h",
                 k, a_valid_o, a_idx_o, a_data_o, exp_e[17:16], exp_e[15:0]);
      end
      tick();
    end
    n_checks++; if (a_valid_o !== 1'b0 || a_usage !== 3'd0) begin n_fail++; $display("FAIL stream_empty: got v=%0b u=%0d want v=0 u=0", a_valid_o, a_usage); end
    a_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    logic [2:0] exp_max;
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    a_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_valid_i = 1'b1;
      a_data_i  = 16'hF000 + 16'(k);
      a_idx_i   = 2'd0;
      tick();
    end
    a_valid_i = 1'b0;
    exp_max = StatsOn ? 3'd3 : 3'd0;
    n_checks++; if (a_usage !== 3'd3) begin n_fail++; $display("FAIL flush_pre_usage: got %0d want 3", a_usage); end
    n_checks++; if (a_max !== exp_max) begin n_fail++; $display("FAIL flush_pre_max: got %0d want %0d", a_max, exp_max); end
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    #1;
    n_checks++; if (a_usage !== 3'd0 || a_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_post: got u=%0d v=%0b want u=0 v=0", a_usage, a_valid_o); end
    n_checks++; if (a_max !== 3'd0) begin n_fail++; $display("FAIL flush_max: got %0d want 0", a_max); end
    n_checks++; if (a_ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %0b want 1", a_ready_o); end
  endtask

  task automatic test_reset_mid();
    a_ready_i = 1'b0;
    b_ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      a_valid_i = 1'b1;
      a_data_i  = 16'h6000 + 16'(k);
      a_idx_i   = 2'(k + 2);
      b_valid_i = 1'b1;
      b_data_i  = 16'h7000 + 16'(k);
      b_idx_i   = 2'd1;
      tick();
    end
    a_valid_i = 1'b0;
    b_valid_i = 1'b0;
    #1;
    n_checks++; if (a_usage !== 3'd2 || b_ready_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre: got u=%0d rb=%0b want u=2 rb=0", a_usage, b_ready_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (a_valid_o !== 1'b0 || a_usage !== 3'd0) begin n_fail++; $display("FAIL rstmid_a: got v=%0b u=%0d want v=0 u=0", a_valid_o, a_usage); end
    n_checks++; if (b_usage !== 3'd0 || b_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_cnt: got u=%0d rb=%0b want u=0 rb=1", b_usage, b_ready_o); end
    n_checks++; if (a_max !== 3'd0) begin n_fail++; $display("FAIL rstmid_max: got %0d want 0", a_max); end
    a_ready_i = 1'b1;
    a_valid_i = 1'b1;
    a_data_i  = 16'h5A5A;
    a_idx_i   = 2'd1;
    tick();
    a_valid_i = 1'b0;
    #1;
    n_checks++;
    if (a_valid_o !== 1'b1 || a_data_o !== 16'h5A5A || a_idx_o !== 2'd1) begin
      n_fail++;
      $display("FAIL rstmid_resume: got v=%0b d=%h i=%0d want v=1 d=5a5a i=1", a_valid_o, a_data_o, a_idx_o);
    end
    tick();
    n_checks++; if (a_valid_o !== 1'b0 || a_usage !== 3'd0) begin n_fail++; $display("FAIL rstmid_drain: got v=%0b u=%0d want v=0 u=0", a_valid_o, a_usage); end
    a_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_valid_i = 1'b0; a_ready_i = 1'b0; a_data_i = '0; a_idx_i = '0;
    b_flush = 1'b0; b_valid_i = 1'b0; b_ready_i = 1'b0; b_data_i = '0; b_idx_i = '0;
    test_reset();
    test_fill_drain();
    test_latency();
    test_cap();
    test_full_pop_and_stream();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
